// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive FIFO with unload FSM; idle timeout built when UART_RX_FIFO_TIMEOUT_EN is defined
module uart_rx_fifo #(
    parameter int DEPTH       = 16,
    parameter int AFULL_LVL   = 12,
    parameter int TIMEOUT_CYC = 160
) (
    input  logic                   reset,
    input  logic                   rxclk,
    input  logic [7:0]             rx_data,
    input  logic                   rx_empty,
    output logic                   uld_rx_data,
    input  logic                   flush,
    output logic [7:0]             rd_data,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   almost_full,
    output logic                   rx_timeout
);
    localparam int              AW      = $clog2(DEPTH);
    localparam logic [AW:0]     DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0]     AFULL_C = (AW+1)'(AFULL_LVL);
    localparam logic [AW:0]     CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0]   PTR_ONE = AW'(1);

    if (DEPTH < 4 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0 ||
        AFULL_LVL < 1 || AFULL_LVL > DEPTH ||
        TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_param_err
        $error("uart_rx_fifo: illegal parameter value");
    end

    typedef enum logic [1:0] {S_IDLE, S_UNLOAD, S_CAPTURE} state_t;

    state_t        state_q, state_d;
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          wr_en, rd_en;

    assign rd_valid    = (count_q != '0);
    assign rd_en       = rd_valid && rd_ready;
    assign rd_data     = mem_q[rd_ptr_q];
    assign level       = count_q;
    assign full        = (count_q == DEPTH_C);
    assign almost_full = (count_q >= AFULL_C);

    // Full is only consulted in IDLE; once a byte is in flight its slot is guaranteed.
    always_comb begin
        state_d     = state_q;
        uld_rx_data = 1'b0;
        wr_en       = 1'b0;
        case (state_q)
            S_IDLE:    if (!rx_empty && !full) state_d = S_UNLOAD;
            S_UNLOAD:  begin
                uld_rx_data = 1'b1;
                state_d     = S_CAPTURE;
            end
            S_CAPTURE: begin
                wr_en   = 1'b1;
                state_d = S_IDLE;
            end
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (wr_en && !rd_en) begin
            count_d = count_q + CNT_ONE;
        end else if (!wr_en && rd_en) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // Flush leaves the FSM alone so an unload already strobed still lands its byte.
    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            state_q <= state_d;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (wr_en) begin
                    mem_q[wr_ptr_q] <= rx_data;
                    wr_ptr_q        <= wr_ptr_q + PTR_ONE;
                end
                if (rd_en) begin
                    rd_ptr_q <= rd_ptr_q + PTR_ONE;
                end
                count_q <= count_d;
            end
        end
    end

`ifdef UART_RX_FIFO_TIMEOUT_EN
    localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYC);

    logic [15:0] idle_cnt_q, idle_cnt_d;
    logic        rx_timeout_q, rx_timeout_d;
    logic        idle_clr;

    assign idle_clr = wr_en || rd_en || flush || (count_q == '0);

    always_comb begin
        idle_cnt_d   = idle_cnt_q;
        rx_timeout_d = rx_timeout_q;
        if (idle_clr) begin
            idle_cnt_d   = '0;
            rx_timeout_d = 1'b0;
        end else if (idle_cnt_q != TO_LIM) begin
            idle_cnt_d = idle_cnt_q + 16'd1;
            if (idle_cnt_d == TO_LIM) begin
                rx_timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            idle_cnt_q   <= '0;
            rx_timeout_q <= 1'b0;
        end else begin
            idle_cnt_q   <= idle_cnt_d;
            rx_timeout_q <= rx_timeout_d;
        end
    end

    assign rx_timeout = rx_timeout_q;
`else
    assign rx_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo with a queue-based reference model
module tb_uart_rx_fifo;
    localparam int TO_CYC = 160;

    logic       reset, rxclk;
    logic [7:0] rx_data;
    logic       rx_empty, uld_rx_data, flush;
    logic [7:0] rd_data;
    logic       rd_valid, rd_ready;
    logic [4:0] level;
    logic       full, almost_full, rx_timeout;

    uart_rx_fifo dut (
        .reset(reset), .rxclk(rxclk), .rx_data(rx_data), .rx_empty(rx_empty),
        .uld_rx_data(uld_rx_data), .flush(flush), .rd_data(rd_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .level(level), .full(full),
        .almost_full(almost_full), .rx_timeout(rx_timeout)
    );

    initial begin
        rxclk = 1'b0;
        forever #5 rxclk = ~rxclk;
    end

    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] pend[$];
    bit         cap_pend = 0;
    logic [7:0] cap_byte = 8'h00;
    int         idle = 0;
    int         uld_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        pend.push_back(b);
        rx_empty = 1'b0;
    endtask

    // One clock: advance the reference model by the rules of one edge, then compare.
    task automatic tick();
        bit fl_b, pop_b, cap_b, uld_b;
        int lvl_b;
        fl_b  = flush;
        uld_b = uld_rx_data;
        cap_b = cap_pend;
        lvl_b = exp_q.size();
        pop_b = rd_ready && (lvl_b != 0);
        @(posedge rxclk);
        #1;
        if (fl_b) begin
            exp_q.delete();
        end else begin
            if (pop_b) void'(exp_q.pop_front());
            if (cap_b) exp_q.push_back(cap_byte);
        end
        if (fl_b || pop_b || cap_b || lvl_b == 0) idle = 0;
        else if (idle < 100000) idle++;
        cap_pend = uld_b;
        if (uld_b) begin
            chk("uld_needs_byte", pend.size() != 0, 1);
            if (pend.size() != 0) begin
                cap_byte = pend.pop_front();
                rx_data  = cap_byte;
            end
        end
        rx_empty = (pend.size() == 0);
        if (uld_rx_data) uld_cnt++;
        chk("uld_single_cycle", uld_b && uld_rx_data, 0);
        chk("level", level, exp_q.size());
        chk("rd_valid", rd_valid, exp_q.size() != 0);
        chk("full", full, exp_q.size() == 16);
        chk("almost_full", almost_full, exp_q.size() >= 12);
        if (exp_q.size() != 0) chk("rd_data", rd_data, exp_q[0]);
`ifdef UART_RX_FIFO_TIMEOUT_EN
        chk("rx_timeout", rx_timeout, idle >= TO_CYC);
`else
        chk("rx_timeout", rx_timeout, 0);
`endif
    endtask

    task automatic chk_reset_outputs(input string where);
        chk({where, "_uld"}, uld_rx_data, 0);
        chk({where, "_rd_valid"}, rd_valid, 0);
        chk({where, "_rd_data"}, rd_data, 8'h00);
        chk({where, "_level"}, level, 0);
        chk({where, "_full"}, full, 0);
        chk({where, "_almost_full"}, almost_full, 0);
        chk({where, "_rx_timeout"}, rx_timeout, 0);
    endtask

    task automatic run_until_level(input int tgt, input int max);
        int n = 0;
        while (level !== 5'(tgt) && n < max) begin
            tick();
            n++;
        end
        chk("reach_level", level, tgt);
    endtask

    task automatic wait_uld(input int max);
        int n = 0;
        while (!uld_rx_data && n < max) begin
            tick();
            n++;
        end
        chk("wait_uld", uld_rx_data, 1);
    endtask

    // Spec latency: strobe after edge E, byte visible after E+2 (FIFO assumed empty).
    task automatic single_byte(input logic [7:0] b);
        int n0;
        push(b);
        n0 = uld_cnt;
        wait_uld(20);
        tick();
        chk("uld_width", uld_rx_data, 0);
        chk("valid_not_early", rd_valid, 0);
        tick();
        chk("valid_latency", rd_valid, 1);
        chk("data_latency", rd_data, b);
        chk("level_one", level, 1);
        chk("one_pulse", uld_cnt - n0, 1);
    endtask

    task automatic pop_one();
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b1; flush = 1'b0; rd_ready = 1'b0;
        rx_empty = 1'b1; rx_data = 8'h00;
        @(posedge rxclk);
        #1;
        chk_reset_outputs("por");
        @(posedge rxclk);
        #1;
        reset = 1'b0;

        single_byte(8'hA5);
        pop_one();
        chk("drained_single", level, 0);

        // Fill with a 17th byte waiting behind a full FIFO.
        for (int i = 0; i < 17; i++) push(8'(i));
        run_until_level(16, 200);
        chk("full_at_16", full, 1);
        chk("afull_at_16", almost_full, 1);
        n = uld_cnt;
        repeat (20) tick();
        chk("no_uld_when_full", uld_cnt - n, 0);
        chk("byte_held_in_rx", pend.size(), 1);
        pop_one();
        wait_uld(10);
        tick();
        chk("level_before_concurrent", level, 15);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        chk("concurrent_level", level, 15);
        rd_ready = 1'b1;
        run_until_level(0, 40);
        rd_ready = 1'b0;

        // Flush coinciding with a CAPTURE write drops that byte.
        for (int i = 0; i < 6; i++) push(8'h50 + 8'(i));
        run_until_level(5, 100);
        wait_uld(10);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_level", level, 0);
        chk("flush_valid", rd_valid, 0);
        single_byte(8'h3C);
        pop_one();

        // Flush coinciding with UNLOAD keeps the byte.
        push(8'h77);
        wait_uld(10);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        chk("flush_unload_kept", rd_data, 8'h77);
        chk("flush_unload_level", level, 1);
        pop_one();

        // Idle timeout with one byte parked.
        push(8'h9E);
        run_until_level(1, 20);
        n = 0;
        while (!rx_timeout && n < 300) begin
            tick();
            n++;
        end
`ifdef UART_RX_FIFO_TIMEOUT_EN
        chk("timeout_cycles", n, TO_CYC);
        chk("timeout_set", rx_timeout, 1);
`else
        chk("timeout_absent", rx_timeout, 0);
`endif
        pop_one();
        chk("timeout_clr_pop", rx_timeout, 0);
        repeat (200) tick();

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            if (pend.size() == 0 && $urandom_range(0, 3) == 0) push(8'($urandom));
            rd_ready = ($urandom_range(0, 2) == 0);
            flush    = ($urandom_range(0, 99) == 0);
            tick();
        end
        flush = 1'b0;
        rd_ready = 1'b0;

        // Reset while the unload strobe is high.
        push(8'hC3);
        wait_uld(300);
        reset = 1'b1;
        #1;
        chk_reset_outputs("mid_uld");
        exp_q.delete();
        pend.delete();
        rx_empty = 1'b1;
        cap_pend = 0;
        idle = 0;
        @(posedge rxclk);
        #1;
        chk_reset_outputs("mid_uld_hold");
        reset = 1'b0;
        single_byte(8'h5A);
        pop_one();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
